// File: rtl/count_ud_nl.sv
// count_ud_nl: parametrised synchronous up/down counter with parallel load,
// programmable terminal value MAX and registered wrap pulses OVF/UNF.
// Optional feature: define COUNT_UD_SAT_EN to add the sat port. When sat=1 the
// counter saturates at 0/MAX instead of wrapping.
module count_ud_nl #(
    parameter int               WIDTH = 10,
    parameter logic [WIDTH-1:0] MAX   = {WIDTH{1'b1}},
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             CE,
    input  logic             up,
    input  logic             dw,
    input  logic             LD,
    input  logic [WIDTH-1:0] D,
`ifdef COUNT_UD_SAT_EN
    input  logic             sat,
`endif
    output logic [WIDTH-1:0] Q,
    output logic             UTC,
    output logic             DTC,
    output logic             OVF,
    output logic             UNF
);

    logic [WIDTH-1:0] q_next;
    logic             ovf_next;
    logic             unf_next;
    logic             sat_mode;

`ifdef COUNT_UD_SAT_EN
    assign sat_mode = sat;
`else
    assign sat_mode = 1'b0;
`endif

    assign UTC = (Q == MAX);
    assign DTC = (Q == '0);

    // Next count and wrap flags: load beats count; opposing requests cancel.
    always_comb begin
        q_next   = Q;
        ovf_next = 1'b0;
        unf_next = 1'b0;
        if (LD) begin
            q_next = (D > MAX) ? MAX : D;
        end else if (CE && up && !dw) begin
            if (Q < MAX) begin
                q_next = Q + WIDTH'(1);
            end else if (!sat_mode) begin
                q_next   = '0;
                ovf_next = 1'b1;
            end else begin
                q_next = MAX;
            end
        end else if (CE && dw && !up) begin
            if (Q != '0) begin
                q_next = Q - WIDTH'(1);
            end else if (!sat_mode) begin
                q_next   = MAX;
                unf_next = 1'b1;
            end
        end
    end

    // Count register and wrap pulses; synchronous reset wins over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            Q   <= INIT;
            OVF <= 1'b0;
            UNF <= 1'b0;
        end else begin
            Q   <= q_next;
            OVF <= ovf_next;
            UNF <= unf_next;
        end
    end

endmodule

// File: tb/tb_count_ud_nl.sv
// tb_count_ud_nl: two counter instances (4-bit MAX=9 INIT=0, 10-bit full range
// INIT=7) driven from shared inputs, checked every cycle against an
// arithmetic model, plus directed literal checks. Saturation checks exist
// only when COUNT_UD_SAT_EN is defined.
module tb_count_ud_nl;

    localparam int MAX_A  = 9;
    localparam int INIT_A = 0;
    localparam int MAX_B  = 1023;
    localparam int INIT_B = 7;

    logic       clk = 1'b0;
    logic       rst, ce, up, dw, ld, sat;
    logic [9:0] d;
    logic [3:0] q_a;
    logic [9:0] q_b;
    logic       utc_a, dtc_a, ovf_a, unf_a;
    logic       utc_b, dtc_b, ovf_b, unf_b;

    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int m_qa, m_qb;
    bit m_ova, m_una, m_ovb, m_unb;
    bit m_valid = 0;

    always #5 clk = ~clk;

    count_ud_nl #(.WIDTH(4), .MAX(4'd9), .INIT(4'd0)) dut_a (
        .clk(clk), .rst(rst), .CE(ce), .up(up), .dw(dw), .LD(ld), .D(d[3:0]),
`ifdef COUNT_UD_SAT_EN
        .sat(sat),
`endif
        .Q(q_a), .UTC(utc_a), .DTC(dtc_a), .OVF(ovf_a), .UNF(unf_a)
    );

    count_ud_nl #(.WIDTH(10), .INIT(10'd7)) dut_b (
        .clk(clk), .rst(rst), .CE(ce), .up(up), .dw(dw), .LD(ld), .D(d),
`ifdef COUNT_UD_SAT_EN
        .sat(sat),
`endif
        .Q(q_b), .UTC(utc_b), .DTC(dtc_b), .OVF(ovf_b), .UNF(unf_b)
    );

    function automatic void chk(string nm, int act, int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endfunction

    // Counting modulo (max+1) in wrap mode, clamped arithmetic in saturate mode.
    function automatic void model_step(input int q, input int max, input int init,
                                       input int dval, input bit s,
                                       output int nq, output bit novf, output bit nunf);
        nq = q; novf = 0; nunf = 0;
        if (rst) nq = init;
        else if (ld) nq = (dval > max) ? max : dval;
        else if (ce && (up != dw)) begin
            if (up) begin
                if (s) nq = (q + 1 > max) ? max : q + 1;
                else begin
                    nq   = (q + 1) % (max + 1);
                    novf = (q + 1 > max);
                end
            end else begin
                if (s) nq = (q - 1 < 0) ? 0 : q - 1;
                else begin
                    nq   = (q + max) % (max + 1);
                    nunf = (q == 0);
                end
            end
        end
    endfunction

    // Reference model advances on every rising edge from the pre-edge inputs.
    always @(posedge clk) begin
        int na, nb;
        bit oa, ua, ob, ub, s;
`ifdef COUNT_UD_SAT_EN
        s = sat;
`else
        s = 0;
`endif
        model_step(m_qa, MAX_A, INIT_A, int'(d[3:0]), s, na, oa, ua);
        model_step(m_qb, MAX_B, INIT_B, int'(d), s, nb, ob, ub);
        m_qa <= na; m_ova <= oa; m_una <= ua;
        m_qb <= nb; m_ovb <= ob; m_unb <= ub;
        if (rst) m_valid <= 1;
    end

    // Compare all outputs of both instances against the model each cycle.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("cmp_q_a",   int'(q_a),   m_qa);
            chk("cmp_utc_a", int'(utc_a), int'(m_qa == MAX_A));
            chk("cmp_dtc_a", int'(dtc_a), int'(m_qa == 0));
            chk("cmp_ovf_a", int'(ovf_a), int'(m_ova));
            chk("cmp_unf_a", int'(unf_a), int'(m_una));
            chk("cmp_q_b",   int'(q_b),   m_qb);
            chk("cmp_utc_b", int'(utc_b), int'(m_qb == MAX_B));
            chk("cmp_dtc_b", int'(dtc_b), int'(m_qb == 0));
            chk("cmp_ovf_b", int'(ovf_b), int'(m_ovb));
            chk("cmp_unf_b", int'(unf_b), int'(m_unb));
        end
    end

    task automatic drive(input bit r, input bit c, input bit u, input bit w,
                         input bit l, input int dv);
        rst = r; ce = c; up = u; dw = w; ld = l; d = 10'(dv);
        @(posedge clk);
        #1;
    endtask

    initial begin
        sat = 0;
        rst = 1; ce = 0; up = 0; dw = 0; ld = 0; d = '0;

        // reset state
        drive(1, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        chk("rst_q_a", int'(q_a), 0);
        chk("rst_dtc_a", int'(dtc_a), 1);
        chk("rst_utc_a", int'(utc_a), 0);
        chk("rst_ovf_a", int'(ovf_a), 0);
        chk("rst_q_b", int'(q_b), 7);
        chk("rst_dtc_b", int'(dtc_b), 0);

        // up count 0..9 then wrap to 0 with OVF
        for (int i = 1; i <= 10; i++) begin
            drive(0, 1, 1, 0, 0, 0);
            chk("up_q_a", int'(q_a), i % 10);
            chk("up_utc_a", int'(utc_a), int'(i == 9));
            chk("up_ovf_a", int'(ovf_a), int'(i == 10));
        end
        drive(0, 0, 0, 0, 0, 0);
        chk("ovf_clear_a", int'(ovf_a), 0);

        // down wrap from 0
        drive(0, 0, 0, 0, 1, 0);
        chk("ld0_q_a", int'(q_a), 0);
        chk("ld0_dtc_a", int'(dtc_a), 1);
        drive(0, 1, 0, 1, 0, 0);
        chk("dwrap_q_a", int'(q_a), 9);
        chk("dwrap_unf_a", int'(unf_a), 1);
        chk("dwrap_dtc_a", int'(dtc_a), 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("unf_clear_a", int'(unf_a), 0);

        // load, clamp, load precedence over count
        drive(0, 0, 0, 0, 1, 5);
        chk("ld5_q_a", int'(q_a), 5);
        drive(0, 0, 0, 0, 1, 13);
        chk("ld13_q_a", int'(q_a), 9);
        chk("ld13_q_b", int'(q_b), 13);
        drive(0, 1, 1, 0, 1, 3);
        chk("ldup_q_a", int'(q_a), 3);

        // simultaneous requests and disabled count hold
        drive(0, 0, 0, 0, 1, 4);
        for (int i = 0; i < 10; i++) begin
            if (i < 5) drive(0, 1, 1, 1, 0, 0);
            else       drive(0, 0, 1, 0, 0, 0);
            chk("hold_q_a", int'(q_a), 4);
            chk("hold_ovf_a", int'(ovf_a), 0);
            chk("hold_unf_a", int'(unf_a), 0);
        end

        // mid-count reset on the wrapping edge of the 10-bit instance
        drive(1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 1016; i++) drive(0, 1, 1, 0, 0, 0);
        chk("top_q_b", int'(q_b), 1023);
        chk("top_utc_b", int'(utc_b), 1);
        drive(1, 1, 1, 0, 0, 0);
        chk("mrst_q_b", int'(q_b), 7);
        chk("mrst_ovf_b", int'(ovf_b), 0);

`ifdef COUNT_UD_SAT_EN
        sat = 1;
        drive(0, 0, 0, 0, 1, 9);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 1, 0, 0, 0);
            chk("sat_hi_q_a", int'(q_a), 9);
            chk("sat_hi_ovf_a", int'(ovf_a), 0);
        end
        drive(0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 0, 1, 0, 0);
            chk("sat_lo_q_a", int'(q_a), 0);
            chk("sat_lo_unf_a", int'(unf_a), 0);
        end
        sat = 0;
`endif

        // randomized traffic, checked by the per-cycle compare process
        for (int i = 0; i < 3000; i++) begin
`ifdef COUNT_UD_SAT_EN
            sat = 1'($urandom_range(0, 3) == 0);
`endif
            drive(bit'($urandom_range(0, 63) == 0),
                  bit'($urandom_range(0, 3) != 0),
                  1'($urandom), 1'($urandom),
                  bit'($urandom_range(0, 7) == 0),
                  int'($urandom_range(0, 1023)));
        end

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
